// File: rtl/byteblast_pkg.sv
// Shared definitions for the program-RAM loader: FSM encoding and frame header default.
package byteblast_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hB8;

endpackage

// File: rtl/prog_loader.sv
// Writer side of the program RAM: receives a MAGIC/LEN/payload/CHK frame and
// writes the payload from address 0, then releases the CPU once the checksum matches.
module prog_loader
  import byteblast_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] MAGIC      = DATA_WIDTH'(MAGIC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  cpu_run,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  state_e                  state_q;
  logic                    in_ready_q;
  logic                    ram_we_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [DATA_WIDTH-1:0]   ram_data_q;
  logic                    cpu_run_q;
  logic                    done_q;
  logic                    error_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   sum_q;
  logic [ADDR_WIDTH-1:0]   wptr_q;

  logic accept_c;
  logic len_bad_c;

  assign accept_c  = in_valid && in_ready_q;
  // A length must be non-zero and fit in the RAM; exactly DEPTH bytes is legal.
  assign len_bad_c = (in_data == '0) || (32'(in_data) > DEPTH);

  // Frame-parsing FSM; every output is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      cpu_run_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      wptr_q     <= '0;
    end else begin
      ram_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept_c && (in_data == MAGIC)) begin
            state_q <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (accept_c) begin
            if (len_bad_c) begin
              state_q    <= ST_ERROR;
              in_ready_q <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q <= ST_DATA;
              cnt_q   <= CNT_W'(in_data);
              sum_q   <= '0;
              wptr_q  <= '0;
            end
          end
        end
        ST_DATA: begin
          if (accept_c) begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= wptr_q;
            ram_data_q <= in_data;
            sum_q      <= sum_q + in_data;
            wptr_q     <= wptr_q + ADDR_WIDTH'(1);
            cnt_q      <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (accept_c) begin
            in_ready_q <= 1'b0;
            if (in_data == sum_q) begin
              state_q   <= ST_DONE;
              done_q    <= 1'b1;
              cpu_run_q <= 1'b1;
            end else begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            cpu_run_q  <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        ST_ERROR: begin
          if (start) begin
            state_q    <= ST_IDLE;
            error_q    <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          cpu_run_q  <= 1'b0;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign cpu_run  = cpu_run_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-byte output vectors plus frame-level sequences
// checked against a shadow RAM fed by the write strobe.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_data;
  logic       cpu_run;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  prog_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .cpu_run  (cpu_run),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Shadow RAM: each location remembers which test generation last wrote it.
  logic [7:0] mem [64];
  int         mem_gen [64];
  int         gen = 0;
  int         we_count = 0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_data;
      mem_gen[ram_addr] <= gen;
      we_count          <= we_count + 1;
    end
  end

  typedef struct packed {
    logic       start_first;
    logic [7:0] din;
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
    logic       dn;
    logic       er;
    logic       rn;
    logic       rd;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [18:0] obs();
    return {ram_we, ram_addr, ram_data, done, error, cpu_run, in_ready};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic check_mem(input int a, input logic [7:0] v);
    check($sformatf("mem%0d", a), {23'd0, mem_gen[a] == gen, mem[a]}, {23'd0, 1'b1, v});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 8'hB8;
    repeat (n) @(negedge clk);
  endtask

  // Present one byte after `gap` idle cycles; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    idle(gap);
    n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].start_first) begin
        idle(0);
        pulse_start();
        gen++;
      end
      send(vecs[i].din, 0);
      check($sformatf("vec%0d", i), {13'd0, obs()},
            {13'd0, vecs[i].we, vecs[i].addr, vecs[i].data,
             vecs[i].dn, vecs[i].er, vecs[i].rn, vecs[i].rd});
    end
    idle(0);
  endtask

  initial begin
    int         base;
    logic [7:0] sum;

    //            st   din    we  addr   data   dn er rn rd
    vecs[0]  = '{1'b0, 8'hB8, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 8'h04, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'h01, 1'b1, 6'd0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 8'h02, 1'b1, 6'd1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 8'h03, 1'b1, 6'd2, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'h04, 1'b1, 6'd3, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h0A, 1'b0, 6'd3, 8'h04, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h00, 1'b0, 6'd3, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 8'hFF, 1'b0, 6'd3, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 8'hB8, 1'b0, 6'd3, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'h01, 1'b0, 6'd3, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h55, 1'b1, 6'd0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 8'h55, 1'b0, 6'd0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0};

    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'hB8;
    repeat (3) @(negedge clk);
    check("reset_outs", {13'd0, obs()}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Good 4-byte frame, then junk-prefixed 1-byte frame.
    gen  = 1;
    base = we_count;
    run_vecs(0, 6);
    for (int a = 0; a < 4; a++) check_mem(a, 8'(a + 1));
    check("t1_we_count", we_count - base, 32'd4);
    base = we_count;
    run_vecs(7, 12);
    check_mem(0, 8'h55);
    check("t3_we_count", we_count - base, 32'd1);

    // Bad checksum: payload still lands, error raised, start clears it.
    pulse_start();
    gen++;
    base = we_count;
    send(8'hB8, 0); send(8'h04, 0);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    send(8'h0B, 0);
    idle(0);
    check("t2_flags", {29'd0, done, error, cpu_run}, 32'b010);
    for (int a = 0; a < 4; a++) check_mem(a, 8'(a + 1));
    check("t2_we_count", we_count - base, 32'd4);
    pulse_start();
    check("t2_after_start", {29'd0, error, in_ready, cpu_run}, 32'b010);

    // Illegal lengths: zero and DEPTH+1.
    base = we_count;
    send(8'hB8, 0); send(8'h00, 0);
    idle(2);
    check("len0_err", {29'd0, error, in_ready, done}, 32'b100);
    pulse_start();
    send(8'hB8, 0); send(8'h41, 0);
    idle(2);
    check("len65_err", {29'd0, error, in_ready, done}, 32'b100);
    check("bad_len_no_we", we_count - base, 32'd0);
    pulse_start();

    // Full-depth frame of 0xFF, back to back.
    gen++;
    base = we_count;
    send(8'hB8, 0); send(8'h40, 0);
    for (int i = 0; i < 64; i++) send(8'hFF, 0);
    send(8'hC0, 0);
    idle(1);
    check("full_ff_done", {29'd0, done, error, cpu_run}, 32'b101);
    check("full_ff_we_count", we_count - base, 32'd64);
    for (int a = 0; a < 64; a += 9) check_mem(a, 8'hFF);
    check_mem(63, 8'hFF);
    pulse_start();

    // Full-depth frame with address-valued payload and random valid gaps.
    gen++;
    base = we_count;
    sum  = 8'h00;
    send(8'hB8, $urandom_range(0, 2)); send(8'h40, $urandom_range(0, 2));
    for (int i = 0; i < 64; i++) begin
      send(8'(i), $urandom_range(0, 2));
      sum = sum + 8'(i);
    end
    check("gap_chk_model", {24'd0, sum}, 32'hE0);
    send(8'hE0, $urandom_range(0, 2));
    idle(1);
    check("gap_done", {29'd0, done, error, cpu_run}, 32'b101);
    check("gap_we_count", we_count - base, 32'd64);
    for (int a = 0; a < 64; a += 7) check_mem(a, 8'(a));
    check_mem(63, 8'd63);
    pulse_start();

    // Start mid-frame is ignored; reset mid-frame aborts; next frame loads.
    gen++;
    base = we_count;
    send(8'hB8, 0); send(8'h03, 0); send(8'h11, 0);
    idle(0);
    pulse_start();
    send(8'h22, 0);
    check("start_ignored", {13'd0, obs()}, {13'd0, 1'b1, 6'd1, 8'h22, 4'b0001});
    idle(1);
    check("gap_no_we", {30'd0, ram_we, in_ready}, 32'b01);
    reset = 1'b0;
    #1;
    check("midframe_reset", {13'd0, obs()}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rereset", {31'd0, in_ready}, 32'd1);
    send(8'hB8, 0); send(8'h02, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'h77, 0);
    idle(1);
    check("post_reset_done", {29'd0, done, error, cpu_run}, 32'b101);
    check_mem(0, 8'h33);
    check_mem(1, 8'h44);
    check("post_reset_we_count", we_count - base, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
